// File: rtl/clu_pkg.sv
// Shared constants and the carry-slice recurrence used by the pipelined carry unit
// and by the legacy gate-level unit's bench model.
package clu_pkg;

  localparam int unsigned CLU_WIDTH  = 16;
  localparam int unsigned CLU_STAGES = 4;
  localparam int unsigned CLU_MAX_B  = 64;

  typedef struct packed {
    logic [CLU_MAX_B-1:0] c;
    logic                 cout;
  } carry_slice_t;

  // Resolves the low n bits of a slice: c[i] is the carry out of bit i.
  function automatic carry_slice_t carry_step(
    input logic [CLU_MAX_B-1:0] g_n,
    input logic [CLU_MAX_B-1:0] p,
    input logic                 cin,
    input int unsigned          n
  );
    carry_slice_t r;
    logic         k;
    r = '0;
    k = cin;
    for (int unsigned i = 0; i < CLU_MAX_B; i++) begin
      if (i < n) begin
        k      = ~g_n[i] | (p[i] & k);
        r.c[i] = k;
      end
    end
    r.cout = k;
    return r;
  endfunction

endpackage

// File: rtl/clu_stage.sv
// One registered carry slice: resolves bits [OFFSET, OFFSET+B) of the travelling
// carry vector and carries the operands and boundary carry on to the next slice.
module clu_stage
  import clu_pkg::*;
#(
  parameter int unsigned B      = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned OFFSET = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             load_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] g_n_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic             k_i,
  output logic             v_o,
  output logic [WIDTH-1:0] g_n_o,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] c_o,
  output logic             k_o
);

  logic                 v_q, v_d;
  logic [WIDTH-1:0]     g_n_q, p_q, c_q, c_d;
  logic                 k_q;
  logic [CLU_MAX_B-1:0] g_n_ext, p_ext;
  carry_slice_t         res;
  logic                 unused_hi;

  always_comb begin
    g_n_ext          = '0;
    p_ext            = '0;
    g_n_ext[B-1:0]   = g_n_i[OFFSET +: B];
    p_ext[B-1:0]     = p_i[OFFSET +: B];
    res              = carry_step(g_n_ext, p_ext, k_i, B);
    c_d              = c_i;
    c_d[OFFSET +: B] = res.c[B-1:0];
  end

  assign unused_hi = |(res.c >> B);

  // Bubbles are overwritten: a stage takes its upstream valid bit whenever it loads.
  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (load_i) begin
      v_d = v_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q   <= 1'b0;
      g_n_q <= '0;
      p_q   <= '0;
      c_q   <= '0;
      k_q   <= 1'b0;
    end else begin
      v_q <= v_d;
      if (load_i && v_i) begin
        g_n_q <= g_n_i;
        p_q   <= p_i;
        c_q   <= c_d;
        k_q   <= res.cout;
      end
    end
  end

  assign v_o   = v_q;
  assign g_n_o = g_n_q;
  assign p_o   = p_q;
  assign c_o   = c_q;
  assign k_o   = k_q;

endmodule

// File: rtl/m_clu_pipe.sv
// Pipelined carry-lookahead unit: STAGES registered slices with valid/ready flow
// control, bubble collapse and synchronous flush.
module m_clu_pipe
  import clu_pkg::*;
#(
  parameter int unsigned WIDTH  = CLU_WIDTH,
  parameter int unsigned STAGES = CLU_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_n,
  input  logic [WIDTH-1:0] p,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c
);

  localparam int unsigned B = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("m_clu_pipe: WIDTH must be a multiple of STAGES");
  end
  if (B > CLU_MAX_B) begin : g_bad_slice
    $error("m_clu_pipe: slice width exceeds CLU_MAX_B");
  end

  logic             v_a   [STAGES+1];
  logic [WIDTH-1:0] g_n_a [STAGES+1];
  logic [WIDTH-1:0] p_a   [STAGES+1];
  logic [WIDTH-1:0] c_a   [STAGES+1];
  logic             k_a   [STAGES+1];
  logic [STAGES:0]  ld_w;

  assign v_a[0]   = in_valid;
  assign g_n_a[0] = g_n;
  assign p_a[0]   = p;
  assign c_a[0]   = '0;
  assign k_a[0]   = cin;

  // Load chain runs back from the output so a draining pipe accepts without a bubble.
  always_comb begin
    ld_w         = '0;
    ld_w[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      ld_w[STAGES-1-i] = ~v_a[STAGES-i] | ld_w[STAGES-i];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    clu_stage #(
      .B      (B),
      .WIDTH  (WIDTH),
      .OFFSET (s * B)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .flush  (flush),
      .load_i (ld_w[s]),
      .v_i    (v_a[s]),
      .g_n_i  (g_n_a[s]),
      .p_i    (p_a[s]),
      .c_i    (c_a[s]),
      .k_i    (k_a[s]),
      .v_o    (v_a[s+1]),
      .g_n_o  (g_n_a[s+1]),
      .p_o    (p_a[s+1]),
      .c_o    (c_a[s+1]),
      .k_o    (k_a[s+1])
    );
  end

  assign in_ready  = ld_w[0];
  assign out_valid = v_a[STAGES];
  assign c         = c_a[STAGES];

endmodule
